obram_arbiter: RTL and testbench

Shares the single-port output BRAM (OUT×OUT 32-bit convolution results) between two requesters: the convolution store path (writer) and the readback/streaming path (reader). It accepts at most one request per cycle using round-robin arbitration and drives the BRAM port from registers. It tracks the fixed read latency so the reader gets a `rd_valid` strobe aligned with `bram_dout`, and counts accepted writes so the controller knows when a full output frame is in memory.

---
 rtl/conv_pkg.sv | 9 +
 rtl/rr_arb2.sv | 23 ++
 rtl/obram_arbiter.sv | 102 ++++++++++
 tb/tb_obram_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: output-frame geometry and BRAM port constants shared by the conv output path.
package conv_pkg;
    localparam int OUT          = 126;
    localparam int DEPTH        = OUT * OUT;
    localparam int ADDR_WIDTH   = $clog2(DEPTH);
    localparam int DATA_WIDTH   = 32;
    localparam int READ_LATENCY = 2;
    typedef enum logic {LW_RD = 1'b0, LW_WR = 1'b1} winner_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant between writer and reader with frame clear.
module rr_arb2
    import conv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic wr_req,
    input  logic rd_req,
    output logic wr_gnt,
    output logic rd_gnt
);
    winner_e last_q, last_d;
    always_comb begin
        wr_gnt = !clear && wr_req && (!rd_req || last_q == LW_RD);
        rd_gnt = !clear && rd_req && (!wr_req || last_q == LW_WR);
        last_d = clear ? LW_RD : wr_gnt ? LW_WR : rd_gnt ? LW_RD : last_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= LW_RD;
        else      last_q <= last_d;
    end
endmodule

// File: rtl/obram_arbiter.sv
// obram_arbiter: shares the output BRAM port between store and readback paths,
// tracks read latency and counts in-range writes per frame.
module obram_arbiter #(
    parameter int DEPTH        = conv_pkg::DEPTH,
    parameter int ADDR_WIDTH   = conv_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = conv_pkg::DATA_WIDTH,
    parameter int READ_LATENCY = conv_pkg::READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  frame_written,
    output logic                  addr_err
);
    localparam int RL = READ_LATENCY;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    logic                  acc, in_rng;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  en_q, en_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [RL-1:0]         vld_q, vld_d, oor_q, oor_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  frame_q, frame_d, err_q, err_d;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .wr_req (wr_req),
        .rd_req (rd_req),
        .wr_gnt (wr_gnt),
        .rd_gnt (rd_gnt)
    );

    // Out-of-range requests are granted but never reach the BRAM port.
    always_comb begin
        acc      = wr_gnt || rd_gnt;
        acc_addr = wr_gnt ? wr_addr : rd_addr;
        in_rng   = {1'b0, acc_addr} < DEPTH_W;
        en_d     = acc && in_rng;
        we_d     = wr_gnt && in_rng;
        addr_d   = acc ? acc_addr : addr_q;
        din_d    = wr_gnt ? wr_data : din_q;
        vld_d    = RL'({vld_q, rd_gnt});
        oor_d    = RL'({oor_q, rd_gnt && !in_rng});
        cnt_d    = clear ? '0 : cnt_q + CW'(we_d && cnt_q != DEPTH_W);
        frame_d  = !clear && (frame_q || cnt_d == DEPTH_W);
        err_d    = !clear && (err_q || (acc && !in_rng));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            vld_q   <= '0;
            oor_q   <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            vld_q   <= vld_d;
            oor_q   <= oor_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign bram_en       = en_q;
    assign bram_we       = we_q;
    assign bram_addr     = addr_q;
    assign bram_din      = din_q;
    assign rd_valid      = vld_q[RL-1];
    assign rd_data       = oor_q[RL-1] ? '0 : bram_dout;
    assign wr_count      = cnt_q;
    assign frame_written = frame_q;
    assign addr_err      = err_q;
endmodule

// File: tb/tb_obram_arbiter.sv
// tb_obram_arbiter: directed checks of arbitration, read timing, counters, clear and reset.
module tb_obram_arbiter;
    import conv_pkg::*;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic          clk = 1'b0, rst = 1'b0, clear = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_gnt, rd_gnt, rd_valid, bram_en, bram_we, frame_written, addr_err;
    logic [DW-1:0] rd_data, bram_din;
    logic [AW-1:0] bram_addr;
    logic [AW:0]   wr_count;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] dout_q = '0;
    int            n_chk = 0, n_err = 0;

    obram_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_gnt        (wr_gnt),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_dout     (dout_q),
        .wr_count      (wr_count),
        .frame_written (frame_written),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    // BRAM model: data valid two edges after the arbiter's command edge.
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         dout_q <= mem[bram_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_ctl", {bram_en, bram_we, rd_valid, frame_written, addr_err}, 0);
        check("rst_regs", {bram_addr, bram_din, wr_count}, 0);
        tick();
        rst = 1'b1;
        // single write then read of addr 5
        wr_req = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        #1 check("wr_gnt_first", {wr_gnt, rd_gnt}, 2'b10);
        tick();
        check("wr_issue", {bram_en, bram_we, bram_addr, bram_din}, {2'b11, 14'd5, 32'hDEADBEEF});
        check("wr_cnt1", wr_count, 1);
        wr_req = 0; rd_req = 1; rd_addr = 5;
        #1 check("rd_gnt", {wr_gnt, rd_gnt}, 2'b01);
        tick();
        rd_req = 0;
        check("rd_issue", {bram_en, bram_we, bram_addr}, {2'b10, 14'd5});
        check("rd_vld_early", rd_valid, 0);
        tick();
        check("rd_vld", rd_valid, 1);
        check("rd_data", rd_data, 32'hDEADBEEF);
        // contention: W,R,W,R,W,R on addrs 0..2
        for (int i = 0, wi = 0, ri = 0; i < 6; i++) begin
            tick();
            if (i == 3 || i == 5) begin
                check("cont_vld", rd_valid, 1);
                check("cont_data", rd_data, 32'h100 + (i - 3) / 2);
            end else check("cont_novld", rd_valid, 0);
            wr_req = 1; rd_req = 1;
            wr_addr = AW'(wi); wr_data = DW'(32'h100 + wi); rd_addr = AW'(ri);
            #1 check("cont_gnt", {wr_gnt, rd_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i % 2 == 0) wi++; else ri++;
        end
        tick();
        wr_req = 0; rd_req = 0;
        check("cont_novld6", rd_valid, 0);
        check("cont_cnt", wr_count, 4);
        tick();
        check("cont_vld7", {rd_valid, rd_data}, {1'b1, 32'h102});
        // out-of-range read and write
        rd_req = 1; rd_addr = 14'd15876;
        #1 check("oor_rd_gnt", rd_gnt, 1);
        tick();
        rd_req = 0;
        check("oor_rd_en", bram_en, 0);
        check("oor_err", addr_err, 1);
        wr_req = 1; wr_addr = 14'd16000; wr_data = 32'h55;
        #1 check("oor_wr_gnt", wr_gnt, 1);
        tick();
        wr_req = 0;
        check("oor_rd_vld", {rd_valid, rd_data}, {1'b1, 32'h0});
        check("oor_wr_en", bram_en, 0);
        check("oor_wr_cnt", wr_count, 4);
        // clear with a read in flight and both requests high
        wr_req = 1; wr_addr = 7; wr_data = 32'h777; rd_req = 1; rd_addr = 1;
        #1 check("pre_clr_gnt", {wr_gnt, rd_gnt}, 2'b01);
        tick();
        clear = 1;
        #1 check("clr_gnt", {wr_gnt, rd_gnt}, 2'b00);
        tick();
        clear = 0; wr_req = 0; rd_req = 0;
        check("clr_state", {wr_count, frame_written, addr_err, bram_en}, 0);
        check("clr_inflight", {rd_valid, rd_data}, {1'b1, 32'h101});
        wr_req = 1; wr_addr = 8;
        #1 check("lw_set_gnt", wr_gnt, 1);
        tick();
        wr_req = 0; clear = 1;
        tick();
        clear = 0; wr_req = 1; rd_req = 1; wr_addr = 9; rd_addr = 0;
        #1 check("lw_clr_gnt", {wr_gnt, rd_gnt}, 2'b10);
        wr_req = 0; rd_req = 0; clear = 1;
        tick();
        clear = 0;
        check("fill_start", wr_count, 0);
        // frame fill with saturation
        for (int i = 0; i < DEPTH; i++) begin
            wr_req = 1; wr_addr = AW'(i); wr_data = DW'(i);
            if (i == DEPTH - 1) check("fill_prev", {wr_count, frame_written}, {15'(DEPTH - 1), 1'b0});
            tick();
        end
        check("fill_full", {wr_count, frame_written}, {15'(DEPTH), 1'b1});
        wr_addr = 0;
        #1 check("extra_gnt", wr_gnt, 1);
        tick();
        wr_req = 0;
        check("fill_sat", {wr_count, frame_written}, {15'(DEPTH), 1'b1});
        // async reset mid-read
        rd_req = 1; rd_addr = 3;
        #1 check("rst_rd_gnt", rd_gnt, 1);
        tick();
        rd_req = 0;
        check("rst_rd_issue", bram_en, 1);
        #2 rst = 0;
        #1 check("async_ctl", {bram_en, bram_we, rd_valid, frame_written, addr_err}, 0);
        check("async_regs", {bram_addr, bram_din, wr_count}, 0);
        tick();
        tick();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_novld", rd_valid, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
